// File: rtl/lcd_draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module : lcd_draw_sequencer
// Brief  : Sequences display init, background draw and settle, then shares the
//          line engine round-robin among NUM_REQ requesters, with a watchdog.
// Rev    : 1.0  initial release
// ============================================================================
module lcd_draw_sequencer #(
    parameter  int NUM_REQ = 4,
    parameter  int TIMEOUT = 50000,
    parameter  int TO_W    = 16,
    parameter  int SETTLE  = 4,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               doneInit,
    input  logic               doneLine,
    input  logic               redraw,
    input  logic [NUM_REQ-1:0] req,
    output logic               enInit,
    output logic               enLine,
    output logic               drawCanvas,
    output logic               idle,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               timeout
);

    localparam int ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_INIT   = 3'd1,
        S_BG     = 3'd2,
        S_SETTLE = 3'd3,
        S_HOLD   = 3'd4,
        S_DRAW   = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [TO_W-1:0]    r_wdog;
    logic [ST_W-1:0]    r_settle;
    logic [ID_W-1:0]    r_last;
    logic [NUM_REQ-1:0] r_grant;
    logic [ID_W-1:0]    r_grant_id;
    logic               w_timed;
    logic               w_wdog_exp;
    logic               w_timeout;
    logic [ID_W-1:0]    w_idx;
    logic [ID_W-1:0]    w_win;
    logic               w_found;
    logic [NUM_REQ-1:0] w_onehot;

    assign w_timed    = (r_state == S_INIT) || (r_state == S_BG) || (r_state == S_DRAW);
    assign w_wdog_exp = (r_wdog == TO_W'(TIMEOUT - 1));

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_START: w_next = S_INIT;
            S_INIT: begin
                if (doneInit) begin
                    w_next = S_BG;
                end else if (w_wdog_exp) begin
                    w_next    = S_START;
                    w_timeout = 1'b1;
                end
            end
            S_BG: begin
                if (doneLine) begin
                    w_next = S_SETTLE;
                end else if (w_wdog_exp) begin
                    w_next    = S_START;
                    w_timeout = 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_settle == ST_W'(SETTLE - 1)) begin
                    w_next = S_HOLD;
                end
            end
            // A pending repaint always beats the requesters.
            S_HOLD: begin
                if (redraw) begin
                    w_next = S_BG;
                end else if (|req) begin
                    w_next = S_DRAW;
                end
            end
            S_DRAW: begin
                if (doneLine) begin
                    w_next = S_HOLD;
                end else if (w_wdog_exp) begin
                    w_next    = S_START;
                    w_timeout = 1'b1;
                end
            end
            default: w_next = S_START;
        endcase
    end

    // Search starts one past the last winner and wraps, giving round-robin order.
    always_comb begin
        w_idx   = '0;
        w_win   = '0;
        w_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = ID_W'((int'(r_last) + i) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_onehot = NUM_REQ'(1) << w_win;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_START;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wdog   <= '0;
            r_settle <= '0;
        end else begin
            if (w_next != r_state) begin
                r_wdog <= '0;
            end else if (w_timed) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if ((r_state == S_SETTLE) && (w_next == S_SETTLE)) begin
                r_settle <= r_settle + 1'b1;
            end else begin
                r_settle <= '0;
            end
        end
    end

    // The last-winner pointer survives a watchdog abort so rotation resumes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant    <= '0;
            r_grant_id <= '0;
            r_last     <= ID_W'(NUM_REQ - 1);
        end else if ((r_state == S_HOLD) && (w_next == S_DRAW)) begin
            r_grant    <= w_onehot;
            r_grant_id <= w_win;
            r_last     <= w_win;
        end else if ((r_state == S_DRAW) && (w_next != S_DRAW)) begin
            r_grant    <= '0;
            r_grant_id <= '0;
        end
    end

    assign enInit     = (r_state == S_INIT);
    assign enLine     = (r_state == S_BG) || (r_state == S_DRAW);
    assign drawCanvas = (r_state == S_BG);
    assign idle       = (r_state == S_HOLD);
    assign grant      = r_grant;
    assign grant_id   = r_grant_id;
    assign timeout    = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_lcd_draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_lcd_draw_sequencer
// Brief  : Scenario tasks with randomized stimulus against a round-robin model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_lcd_draw_sequencer;

    localparam int NR  = 4;
    localparam int TO  = 8;
    localparam int SET = 4;

    // Flag order: {enInit, enLine, drawCanvas, idle, timeout}
    localparam logic [4:0] F_ZERO = 5'b00000;
    localparam logic [4:0] F_INIT = 5'b10000;
    localparam logic [4:0] F_BG   = 5'b01100;
    localparam logic [4:0] F_DRAW = 5'b01000;
    localparam logic [4:0] F_HOLD = 5'b00010;
    localparam logic [4:0] F_TO   = 5'b00001;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          doneInit = 1'b0;
    logic          doneLine = 1'b0;
    logic          redraw   = 1'b0;
    logic [NR-1:0] req      = '0;
    logic          enInit;
    logic          enLine;
    logic          drawCanvas;
    logic          idle;
    logic [NR-1:0] grant;
    logic [1:0]    grant_id;
    logic          timeout;
    logic [10:0]   obs;

    int n_chk  = 0;
    int n_fail = 0;
    int m_last = NR - 1;

    always #5 clk = ~clk;

    lcd_draw_sequencer #(
        .NUM_REQ (NR),
        .TIMEOUT (TO),
        .TO_W    (4),
        .SETTLE  (SET)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .doneInit   (doneInit),
        .doneLine   (doneLine),
        .redraw     (redraw),
        .req        (req),
        .enInit     (enInit),
        .enLine     (enLine),
        .drawCanvas (drawCanvas),
        .idle       (idle),
        .grant      (grant),
        .grant_id   (grant_id),
        .timeout    (timeout)
    );

    assign obs = {enInit, enLine, drawCanvas, idle, timeout, grant, grant_id};

    function automatic int rr_pick(input logic [NR-1:0] r, input int last);
        logic [NR-1:0] t;
        for (int k = 1; k <= NR; k++) begin
            t = r >> ((last + k) % NR);
            if (t[0]) return (last + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [10:0] ev(input logic [4:0] f, input int win);
        if (win < 0) return {f, 4'b0000, 2'b00};
        return {f, 4'(1 << win), 2'(win)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            n_chk++;
            if (obs !== ev(F_ZERO, -1)) begin
                n_fail++;
                $display("FAIL reset: got %b want %b", obs, ev(F_ZERO, -1));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (obs !== ev(F_ZERO, -1)) begin
            n_fail++;
            $display("FAIL release_start: got %b want %b", obs, ev(F_ZERO, -1));
        end
        m_last = NR - 1;
    endtask

    // Entered at the first BACKGROUND cycle; ends in the first HOLD cycle.
    task automatic run_bg(input int d);
        for (int i = 0; i <= d; i++) begin
            if (i > 0) @(negedge clk);
            doneLine = (i == d);
            #1;
            n_chk++;
            if (obs !== ev(F_BG, -1)) begin
                n_fail++;
                $display("FAIL background c%0d: got %b want %b", i, obs, ev(F_BG, -1));
            end
        end
        for (int i = 0; i < SET; i++) begin
            @(negedge clk);
            doneLine = 1'b0;
            #1;
            n_chk++;
            if (obs !== ev(F_ZERO, -1)) begin
                n_fail++;
                $display("FAIL settle c%0d: got %b want %b", i, obs, ev(F_ZERO, -1));
            end
        end
        @(negedge clk); #1;
        n_chk++;
        if (obs !== ev(F_HOLD, -1)) begin
            n_fail++;
            $display("FAIL hold_after_settle: got %b want %b", obs, ev(F_HOLD, -1));
        end
    endtask

    task automatic bring_up(input int k, input int d);
        for (int i = 0; i <= k; i++) begin
            @(negedge clk);
            doneInit = (i == k);
            #1;
            n_chk++;
            if (obs !== ev(F_INIT, -1)) begin
                n_fail++;
                $display("FAIL init c%0d: got %b want %b", i, obs, ev(F_INIT, -1));
            end
        end
        @(negedge clk);
        doneInit = 1'b0;
        run_bg(d);
    endtask

    // Entered in a HOLD cycle; ends in the HOLD cycle after the DRAW.
    task automatic do_draw(input logic [NR-1:0] reqv, input int dwell);
        int win;
        win    = rr_pick(reqv, m_last);
        req    = reqv;
        redraw = 1'b0;
        @(negedge clk);
        doneLine = (dwell == 0);
        #1;
        n_chk++;
        if (obs !== ev(F_DRAW, win)) begin
            n_fail++;
            $display("FAIL draw_grant req=%b: got %b want %b", reqv, obs, ev(F_DRAW, win));
        end
        m_last = win;
        for (int i = 1; i <= dwell; i++) begin
            @(negedge clk);
            doneLine = (i == dwell);
            doneInit = 1'($urandom_range(0, 1));
            redraw   = 1'($urandom_range(0, 1));
            req      = NR'($urandom);
            #1;
            n_chk++;
            if (obs !== ev(F_DRAW, win)) begin
                n_fail++;
                $display("FAIL draw_busy c%0d: got %b want %b", i, obs, ev(F_DRAW, win));
            end
        end
        @(negedge clk);
        doneLine = 1'b0;
        doneInit = 1'b0;
        redraw   = 1'b0;
        req      = '0;
        #1;
        n_chk++;
        if (obs !== ev(F_HOLD, -1)) begin
            n_fail++;
            $display("FAIL draw_release: got %b want %b", obs, ev(F_HOLD, -1));
        end
    endtask

    task automatic test_round_robin();
        repeat (6) do_draw(4'b1011, 3);
    endtask

    task automatic test_stray();
        repeat (6) begin
            doneLine = 1'($urandom_range(0, 1));
            doneInit = 1'($urandom_range(0, 1));
            req      = '0;
            @(negedge clk); #1;
            n_chk++;
            if (obs !== ev(F_HOLD, -1)) begin
                n_fail++;
                $display("FAIL stray_hold: got %b want %b", obs, ev(F_HOLD, -1));
            end
        end
        doneLine = 1'b0;
        doneInit = 1'b0;
    endtask

    task automatic test_redraw();
        redraw = 1'b1;
        req    = 4'b0100;
        @(negedge clk);
        redraw = 1'b0;
        run_bg(4);
        do_draw(4'b0100, 2);
    endtask

    task automatic test_boundary();
        do_draw(NR'($urandom_range(1, 15)), TO - 1);
        do_draw(NR'($urandom_range(1, 15)), TO - 2);
    endtask

    task automatic test_timeout();
        logic [NR-1:0] reqv;
        int            win;
        reqv = NR'($urandom_range(1, 15));
        win  = rr_pick(reqv, m_last);
        req  = reqv;
        @(negedge clk); #1;
        n_chk++;
        if (obs !== ev(F_DRAW, win)) begin
            n_fail++;
            $display("FAIL timeout_grant: got %b want %b", obs, ev(F_DRAW, win));
        end
        m_last = win;
        for (int i = 2; i <= TO; i++) begin
            @(negedge clk);
            req = NR'($urandom);
            #1;
            n_chk++;
            if (obs !== ev((i == TO) ? (F_DRAW | F_TO) : F_DRAW, win)) begin
                n_fail++;
                $display("FAIL watchdog c%0d: got %b want %b", i, obs,
                         ev((i == TO) ? (F_DRAW | F_TO) : F_DRAW, win));
            end
        end
        @(negedge clk);
        req = '0;
        #1;
        n_chk++;
        if (obs !== ev(F_ZERO, -1)) begin
            n_fail++;
            $display("FAIL timeout_start: got %b want %b", obs, ev(F_ZERO, -1));
        end
        bring_up(2, 3);
        do_draw(4'b1111, 1);
    endtask

    task automatic test_random();
        repeat (25) begin
            case ($urandom_range(0, 3))
                0: begin
                    redraw = 1'b1;
                    req    = NR'($urandom);
                    @(negedge clk);
                    redraw = 1'b0;
                    run_bg($urandom_range(0, TO - 1));
                end
                1: begin
                    req = '0;
                    @(negedge clk); #1;
                    n_chk++;
                    if (obs !== ev(F_HOLD, -1)) begin
                        n_fail++;
                        $display("FAIL idle_hold: got %b want %b", obs, ev(F_HOLD, -1));
                    end
                end
                default: do_draw(NR'($urandom_range(1, 15)), $urandom_range(0, TO - 1));
            endcase
        end
    endtask

    task automatic test_reset_mid_draw();
        logic [NR-1:0] reqv;
        int            win;
        reqv = NR'($urandom_range(1, 15));
        win  = rr_pick(reqv, m_last);
        req  = reqv;
        @(negedge clk); #1;
        n_chk++;
        if (obs !== ev(F_DRAW, win)) begin
            n_fail++;
            $display("FAIL middraw_grant: got %b want %b", obs, ev(F_DRAW, win));
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs !== ev(F_DRAW, win)) begin
            n_fail++;
            $display("FAIL middraw_before_edge: got %b want %b", obs, ev(F_DRAW, win));
        end
        @(negedge clk);
        req = '0;
        #1;
        n_chk++;
        if (obs !== ev(F_ZERO, -1)) begin
            n_fail++;
            $display("FAIL middraw_reset: got %b want %b", obs, ev(F_ZERO, -1));
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_last = NR - 1;
        bring_up(1, 2);
        do_draw(4'b1111, 0);
    endtask

    initial begin
        test_reset();
        bring_up(3, 5);
        test_round_robin();
        test_stray();
        test_redraw();
        test_boundary();
        test_timeout();
        test_random();
        test_reset_mid_draw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got expired want finished");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire

// File: doc/lcd_draw_sequencer.md
# lcd_draw_sequencer

Top-level draw sequencer for the LCD path and the parametrised successor of the single-channel display controller FSM. It sequences display initialisation, a full-canvas background draw and a settle interval, then arbitrates round-robin among `NUM_REQ` line/sprite draw requesters for the shared line-draw engine. Every engine phase is guarded by a watchdog timeout, and a background redraw can be requested at runtime. The block sits between the init and line-draw engines and the game-logic requesters.

## Interface
- `NUM_REQ`, 4: number of draw requesters; must be ≥ 2.
- `TIMEOUT`, 50000: max cycles allowed in INIT/BACKGROUND/DRAW before abort; must be ≥ 2.
- `TO_W`, 16: watchdog counter width; must satisfy 2^TO_W > TIMEOUT.
- `SETTLE`, 4: cycles spent in SETTLE after the background draw; must be ≥ 1.
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `doneInit` in 1: init engine finished; single-cycle pulse or level.
- `doneLine` in 1: line engine finished the current primitive.
- `redraw` in 1: request a background repaint; level, sampled only in HOLD.
- `req` in NUM_REQ: per-channel draw request; level, held until granted.
- `enInit` out 1: enable for the init engine.
- `enLine` out 1: enable for the line engine.
- `drawCanvas` out 1: line engine draws the background, not a requester primitive.
- `idle` out 1: sequencer is in HOLD.
- `grant` out NUM_REQ: one-hot owner of the line engine during DRAW, else 0.
- `grant_id` out clog2(NUM_REQ): binary index of `grant`; 0 when `grant` is 0.
- `timeout` out 1: one-cycle pulse when the watchdog aborts a phase.

## Operation
- States and transitions:
  - START → INIT, unconditionally.
  - INIT → BACKGROUND on `doneInit`.
  - BACKGROUND → SETTLE on `doneLine`.
  - SETTLE → HOLD after SETTLE cycles.
  - In HOLD, `redraw` → BACKGROUND. Otherwise, if any `req` is set → DRAW. Otherwise stay in HOLD.
  - DRAW → HOLD on `doneLine`.
- Outputs are Moore, decoded from the state register:
  - INIT: `enInit` = 1.
  - BACKGROUND: `enLine` = 1, `drawCanvas` = 1.
  - DRAW: `enLine` = 1.
  - HOLD: `idle` = 1.
  - START and SETTLE: all outputs 0.
- Arbitration:
  - A pointer `last` holds the index of the most recently granted channel.
  - On the HOLD→DRAW transition, the winner is the first set `req` bit searching `last+1, last+2, …` with wrap-around modulo NUM_REQ.
  - The winner's bit is registered into `grant`, `grant_id` is set to its index, and `last` is updated to the winner.
  - `grant` and `grant_id` stay stable for the whole of DRAW and clear on the DRAW→HOLD edge.
  - `redraw` beats `req` in the same cycle.
- Watchdog:
  - A TO_W-bit counter clears on every state change and increments each cycle in INIT, BACKGROUND and DRAW.
  - When it reaches TIMEOUT−1 with no done input, `timeout` pulses and the state goes to START, so the display is fully re-initialised.
  - `last` is preserved across a timeout.
- Done inputs outside their own state are ignored: `doneInit` counts only in INIT, `doneLine` only in BACKGROUND and DRAW.
- Dropping `req` during DRAW does not end DRAW; only `doneLine` or a timeout does.
- Illegal state encodings recover to START on the next edge.

## Timing
- Reset (`rst_n` = 0 at an edge): the state goes to START and `last` = NUM_REQ−1, so channel 0 wins first. All outputs are 0, including `grant`, `grant_id` and `timeout`.
- Reset mid-draw takes effect at that edge; any in-flight engine operation is abandoned.
- Cycle after reset is released: START. The following cycle: INIT, with `enInit` = 1.
- Done-to-next-state latency is 1 cycle. `doneLine` sampled at edge k in DRAW gives `idle` = 1 and `grant` = 0 in cycle k+1.
- HOLD with `req` present → `enLine` and `grant` are valid on the next cycle; the minimum HOLD dwell is 1 cycle.
- A requester's turnaround is at least 2 cycles per primitive (DRAW plus one HOLD cycle), because every DRAW returns through HOLD.
- Done and watchdog expiry in the same cycle: done wins, and `timeout` does not pulse.
- SETTLE lasts exactly SETTLE cycles.

## Test plan
- Power-up: reset 3 cycles, release, pulse `doneInit` in cycle 5, then `doneLine` 10 cycles later.
  - Required: START → INIT → BACKGROUND (`drawCanvas` = 1) → 4 SETTLE cycles → `idle` = 1. All outputs are 0 during reset.
- Round-robin: in HOLD with `req` = 4'b1011 held, answer each DRAW with `doneLine` after 3 cycles.
  - Required: grant order is 0, 1, 3, 0, 1, 3. `grant_id` matches `grant` every time, and each DRAW is separated by one `idle` cycle.
- Redraw priority: `redraw` = 1 and `req` = 4'b0100 in the same HOLD cycle.
  - Required: BACKGROUND is entered with `drawCanvas` = 1 and `grant` = 0. After it completes and SETTLE passes, channel 2 is granted.
- Timeout: with TIMEOUT = 8, enter DRAW and never assert `doneLine`.
  - Required: `timeout` pulses on the 8th DRAW cycle, the next state is START, then INIT.
  - Required: the next grant continues the rotation from the aborted channel.
- Timeout boundary: assert `doneLine` in the same cycle the counter reaches TIMEOUT−1.
  - Required: no `timeout` pulse, and the state returns to HOLD.
- Stray and mid-operation events:
  - `doneLine` pulsed in HOLD, or `doneInit` pulsed in DRAW: no state change.
  - `rst_n` dropped during DRAW: all outputs are 0 on the next cycle.
